encoder_channel_ctrl: RTL and testbench

- Shares one rotary encoder between NUM_CH channel value registers (e.g. R/G/B levels feeding PWM generators).
- Consumes the encoder's free-running wrapping count and converts each change into a signed delta.
- Applies the delta, scaled and saturated, to the currently selected channel.
- A debounced push-button cycles the selected channel.

---
 rtl/encoder_channel_ctrl.sv | 105 ++++++++++
 tb/tb_encoder_channel_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/encoder_channel_ctrl.sv
// encoder_channel_ctrl: routes scaled, saturated rotary-encoder deltas to one of NUM_CH channel registers chosen by a debounced button
// Ports: clk, reset (sync, active-high); enc_value = wrapping encoder count; btn = raw async push-button;
//   ch_values = packed channel registers (channel k at [k*VAL_WIDTH +: VAL_WIDTH]);
//   active_ch = selected channel; updated = one-cycle pulse when ch_values changed on this edge.
// Optional: define ENCODER_CHANNEL_CTRL_IDLE_TIMEOUT_EN to return active_ch to 0 after TIMEOUT_CYCLES idle cycles.
module encoder_channel_ctrl #(
  parameter int ENC_WIDTH = 8,
  parameter int NUM_CH = 3,
  parameter int VAL_WIDTH = 8,
  parameter int STEP = 1,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int TIMEOUT_CYCLES = 2**20,
  localparam int CH_BITS = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [ENC_WIDTH-1:0]        enc_value,
  input  logic                        btn,
  output logic [NUM_CH*VAL_WIDTH-1:0] ch_values,
  output logic [CH_BITS-1:0]          active_ch,
  output logic                        updated
);
  localparam int FW = VAL_WIDTH + ENC_WIDTH + $clog2(STEP) + 2;
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, REL_CHK} state_t;
  if (NUM_CH < 2 || NUM_CH > 8 || DEBOUNCE_CYCLES < 2 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("encoder_channel_ctrl: parameter out of range");
  end
  logic [ENC_WIDTH-1:0] enc_prev_q, delta;
  logic [NUM_CH*VAL_WIDTH-1:0] ch_q, ch_d;
  logic [CH_BITS-1:0] active_ch_q, active_ch_d;
  logic updated_q;
  logic signed [FW-1:0] sum;
  logic [VAL_WIDTH-1:0] cur, sat;
  logic [1:0] sync_q;
  state_t st_q;
  logic [CW-1:0] cnt_q;
  logic press_q, timeout;
  wire btn_s = sync_q[1];
  // Sum is wide enough that delta*STEP can never overflow before clamping.
  always_comb begin
    delta = enc_value - enc_prev_q;
    cur = ch_q[active_ch_q*VAL_WIDTH +: VAL_WIDTH];
    sum = $signed({{(FW-VAL_WIDTH){1'b0}}, cur})
        + $signed({{(FW-ENC_WIDTH){delta[ENC_WIDTH-1]}}, delta}) * $signed(FW'(STEP));
    sat = sum[FW-1] ? '0
        : sum > $signed({{(FW-VAL_WIDTH){1'b0}}, {VAL_WIDTH{1'b1}}}) ? '1
        : sum[VAL_WIDTH-1:0];
    ch_d = ch_q;
    if (delta != '0) ch_d[active_ch_q*VAL_WIDTH +: VAL_WIDTH] = sat;
    active_ch_d = timeout ? '0
                : press_q ? (active_ch_q == CH_BITS'(NUM_CH-1) ? '0 : active_ch_q + 1'b1)
                : active_ch_q;
  end
`ifdef ENCODER_CHANNEL_CTRL_IDLE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] idle_q, idle_d;
  always_comb begin
    timeout = !press_q && delta == '0 && idle_q == TW'(TIMEOUT_CYCLES-1);
    idle_d = (press_q || delta != '0 || timeout) ? '0 : idle_q + 1'b1;
  end
  always_ff @(posedge clk) idle_q <= reset ? '0 : idle_d;
`else
  assign timeout = 1'b0;
`endif
  // enc_prev tracks the input even in reset so releasing reset never produces a delta.
  always_ff @(posedge clk) begin
    enc_prev_q <= enc_value;
    if (reset) begin
      ch_q <= '0;
      active_ch_q <= '0;
      updated_q <= 1'b0;
    end else begin
      ch_q <= ch_d;
      active_ch_q <= active_ch_d;
      updated_q <= ch_d != ch_q;
    end
  end
  // cnt_q free-runs outside the check states; it is zeroed on entry to each.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      st_q <= IDLE;
      cnt_q <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn};
      press_q <= 1'b0;
      cnt_q <= cnt_q + 1'b1;
      case (st_q)
        IDLE: if (btn_s) begin st_q <= PRESS_CHK; cnt_q <= '0; end
        PRESS_CHK:
          if (!btn_s) st_q <= IDLE;
          else if (cnt_q == CW'(DEBOUNCE_CYCLES-1)) begin st_q <= HELD; press_q <= 1'b1; end
        HELD: if (!btn_s) begin st_q <= REL_CHK; cnt_q <= '0; end
        REL_CHK:
          if (btn_s) st_q <= HELD;
          else if (cnt_q == CW'(DEBOUNCE_CYCLES-1)) st_q <= IDLE;
      endcase
    end
  end
  assign ch_values = ch_q;
  assign active_ch = active_ch_q;
  assign updated = updated_q;
endmodule

// File: tb/tb_encoder_channel_ctrl.sv
// tb_encoder_channel_ctrl: directed vector bench for encoder_channel_ctrl
module tb_encoder_channel_ctrl;
  localparam int DB = 8;
  localparam int TO = 100;
  logic clk = 1'b0;
  logic reset, btn;
  logic [7:0] enc_value;
  logic [23:0] ch_values;
  logic [1:0] active_ch;
  logic updated;
  int n_cmp = 0, n_bad = 0;
  int lat;
  typedef struct {logic [7:0] enc; logic [7:0] ch0; logic upd;} vec_t;
  vec_t tbl[27];
  encoder_channel_ctrl #(
    .ENC_WIDTH(8), .NUM_CH(3), .VAL_WIDTH(8), .STEP(1),
    .DEBOUNCE_CYCLES(DB), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .enc_value(enc_value), .btn(btn),
    .ch_values(ch_values), .active_ch(active_ch), .updated(updated)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  // Raises btn and returns on the edge where active_ch changes; latency is 2 sync + DB debounce + 2 register stages.
  task automatic press(input string name);
    logic [1:0] a0;
    a0 = active_ch;
    btn = 1'b1;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (active_ch == a0 && lat < 100);
    chk({name, "_latency"}, lat, DB + 4);
    btn = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    tbl[0]  = '{8'h38, 8'd1,   1'b1};
    tbl[1]  = '{8'h39, 8'd2,   1'b1};
    tbl[2]  = '{8'h3A, 8'd3,   1'b1};
    tbl[3]  = '{8'h3A, 8'd3,   1'b0};
    tbl[4]  = '{8'h3F, 8'd8,   1'b1};
    tbl[5]  = '{8'h3E, 8'd7,   1'b1};
    tbl[6]  = '{8'h30, 8'd0,   1'b1};
    tbl[7]  = '{8'h2F, 8'd0,   1'b0};
    tbl[8]  = '{8'hAE, 8'd127, 1'b1};
    tbl[9]  = '{8'h2D, 8'd254, 1'b1};
    tbl[10] = '{8'h32, 8'd255, 1'b1};
    tbl[11] = '{8'h33, 8'd255, 1'b0};
    tbl[12] = '{8'h33, 8'd255, 1'b0};
    tbl[13] = '{8'h32, 8'd254, 1'b1};
    tbl[14] = '{8'hFF, 8'd203, 1'b1};
    tbl[15] = '{8'h00, 8'd204, 1'b1};
    tbl[16] = '{8'hFF, 8'd203, 1'b1};
    tbl[17] = '{8'h80, 8'd76,  1'b1};
    tbl[18] = '{8'h05, 8'd0,   1'b1};
    tbl[19] = '{8'h04, 8'd0,   1'b0};
    tbl[20] = '{8'h05, 8'd1,   1'b1};
    tbl[21] = '{8'h03, 8'd0,   1'b1};
    tbl[22] = '{8'h03, 8'd0,   1'b0};
    tbl[23] = '{8'h02, 8'd0,   1'b0};
    tbl[24] = '{8'h00, 8'd0,   1'b0};
    tbl[25] = '{8'hFE, 8'd0,   1'b0};
    tbl[26] = '{8'h62, 8'd100, 1'b1};
    reset = 1'b1;
    btn = 1'b0;
    enc_value = 8'h37;
    tick(3);
    chk("rst_ch", ch_values, 0);
    chk("rst_active", active_ch, 0);
    chk("rst_upd", updated, 0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_upd", updated, 0);
      chk("post_rst_ch", ch_values, 0);
    end
    for (int i = 0; i < 27; i++) begin
      enc_value = tbl[i].enc;
      tick();
      chk($sformatf("vec%0d_ch", i), ch_values, {16'h0, tbl[i].ch0});
      chk($sformatf("vec%0d_upd", i), updated, tbl[i].upd);
    end
    for (int i = 0; i < 50; i++) begin
      btn = ((i / 3) % 2) == 1;
      tick();
    end
    chk("bounce_active", active_ch, 0);
    btn = 1'b1;
    tick(2 * DB);
    chk("bounce_hold_active", active_ch, 1);
    btn = 1'b0;
    tick(2 * DB + 4);
    chk("bounce_release_active", active_ch, 1);
    press("press2");
    chk("press2_active", active_ch, 2);
    tick(2 * DB + 4);
    press("press3");
    chk("press3_active", active_ch, 0);
    tick(2 * DB + 4);
    chk("press_ch_untouched", ch_values, {16'h0, 8'd100});
    btn = 1'b1;
    tick(DB + 3);
    chk("coinc_before", active_ch, 0);
    enc_value = 8'h63;
    tick();
    chk("coinc_active", active_ch, 1);
    chk("coinc_ch", ch_values, {16'h0, 8'd101});
    chk("coinc_upd", updated, 1);
    enc_value = 8'h64;
    tick();
    chk("coinc_next_ch", ch_values, {8'd0, 8'd1, 8'd101});
    btn = 1'b0;
    tick(2 * DB + 4);
    chk("coinc_release_active", active_ch, 1);
    press("press_ch2");
    tick(2 * DB + 4);
    enc_value = 8'h60;
    tick();
    chk("ch2_clamp_ch", ch_values, {8'd0, 8'd1, 8'd101});
    chk("ch2_clamp_upd", updated, 0);
    enc_value = 8'h6A;
    tick();
    chk("ch2_up_ch", ch_values, {8'd10, 8'd1, 8'd101});
    chk("ch2_up_upd", updated, 1);
    press("press_wrap");
    chk("press_wrap_active", active_ch, 0);
    tick(2 * DB + 4);
    press("press_pre_rst");
    tick(2 * DB + 4);
    btn = 1'b1;
    tick(6);
    enc_value = 8'h10;
    reset = 1'b1;
    tick();
    chk("midrst_ch", ch_values, 0);
    chk("midrst_active", active_ch, 0);
    chk("midrst_upd", updated, 0);
    btn = 1'b0;
    reset = 1'b0;
    tick();
    chk("midrst_after_ch", ch_values, 0);
    tick(2 * DB + 4);
    chk("midrst_partial_discarded", active_ch, 0);
`ifdef ENCODER_CHANNEL_CTRL_IDLE_TIMEOUT_EN
    press("to_p1");
    tick(2 * DB + 4);
    press("to_p2");
    chk("to_sel", active_ch, 2);
    tick(TO - 1);
    chk("to_hold", active_ch, 2);
    tick();
    chk("to_fire", active_ch, 0);
    press("to_p3");
    tick(2 * DB + 4);
    press("to_p4");
    tick(59);
    enc_value = 8'h11;
    tick();
    tick(TO - 1);
    chk("to_restart_hold", active_ch, 2);
    tick();
    chk("to_restart_fire", active_ch, 0);
`else
    press("noto_p1");
    tick(150);
    chk("noto_hold", active_ch, 1);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
